// File: rtl/logic_result_stage.sv
// Result stage behind the logic unit: a small FIFO of results that also
// precomputes zero/negative/parity flags at push time, so the head flags
// come straight out of storage. Also counts completed (popped) entries.
module logic_result_stage #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_result,
  input  logic [2:0]                 in_sel,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_result,
  output logic [2:0]                 out_sel,
  output logic                       out_zero,
  output logic                       out_neg,
  output logic                       out_parity,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_W-1:0]           done_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  // Pointer and occupancy state; DEPTH is a power of two, so the pointers
  // wrap from DEPTH-1 to 0 by plain binary overflow.
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [LVL_W-1:0] level_reg, level_next;
  logic [CNT_W-1:0] done_cnt_reg, done_cnt_next;

  // Entry storage. Flags are packed as {zero, neg, parity}. Contents are
  // never reset: the head outputs are forced to 0 whenever the buffer is
  // empty, so stale data can never be observed.
  logic [31:0] result_mem [DEPTH];
  logic [2:0]  sel_mem    [DEPTH];
  logic [2:0]  flag_mem   [DEPTH];

  logic push;
  logic pop;
  logic in_zero;
  logic in_neg;
  logic in_parity;

  // Handshakes depend only on registered occupancy, so there is no
  // combinational path from out_ready to in_ready. A full buffer refuses
  // a push even when a pop happens in the same cycle.
  assign in_ready  = (level_reg < LVL_W'(DEPTH));
  assign out_valid = (level_reg != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Flags derived from the incoming result, captured alongside it.
  assign in_zero   = (in_result == 32'h0);
  assign in_neg    = in_result[31];
  assign in_parity = ^in_result;

  // Next-state computation for pointers, occupancy and completion count.
  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    level_next    = level_reg;
    done_cnt_next = done_cnt_reg;
    if (push) begin
      wr_ptr_next = wr_ptr_reg + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_next   = rd_ptr_reg + PTR_W'(1);
      done_cnt_next = done_cnt_reg + CNT_W'(1);
    end
    case ({push, pop})
      2'b10:   level_next = level_reg + LVL_W'(1);
      2'b01:   level_next = level_reg - LVL_W'(1);
      default: level_next = level_reg;
    endcase
  end

  // Control state register; reset discards all buffered entries at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      done_cnt_reg <= '0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      level_reg    <= level_next;
      done_cnt_reg <= done_cnt_next;
    end
  end

  // Entry write on an accepted push; in_result/in_sel are ignored otherwise.
  always_ff @(posedge clk) begin
    if (push) begin
      result_mem[wr_ptr_reg] <= in_result;
      sel_mem[wr_ptr_reg]    <= in_sel;
      flag_mem[wr_ptr_reg]   <= {in_zero, in_neg, in_parity};
    end
  end

  // Head outputs: register reads at the read pointer, zeroed when empty.
  always_comb begin
    out_result = 32'h0;
    out_sel    = 3'b000;
    out_zero   = 1'b0;
    out_neg    = 1'b0;
    out_parity = 1'b0;
    if (out_valid) begin
      out_result = result_mem[rd_ptr_reg];
      out_sel    = sel_mem[rd_ptr_reg];
      {out_zero, out_neg, out_parity} = flag_mem[rd_ptr_reg];
    end
  end

  assign level    = level_reg;
  assign done_cnt = done_cnt_reg;

endmodule

// File: tb/tb_logic_result_stage.sv
// Scoreboard bench for logic_result_stage: an independent occupancy model
// queues expected entries on accepted pushes; a monitor compares the DUT
// head and status outputs against the model every cycle and on reset.
module tb_logic_result_stage;

  localparam int DEPTH = 2;
  localparam int CNT_W = 2;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_result = 32'h0;
  logic [2:0]       in_sel = 3'b000;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_result;
  logic [2:0]       out_sel;
  logic             out_zero;
  logic             out_neg;
  logic             out_parity;
  logic [LVL_W-1:0] level;
  logic [CNT_W-1:0] done_cnt;

  // Expected flags {zero, neg, parity} for the value currently driven.
  logic [2:0]       exp_flags = 3'b000;

  typedef struct packed {
    logic [31:0] r;
    logic [2:0]  s;
    logic [2:0]  f;
  } ent_t;

  ent_t             exp_q[$];
  int               mdl_level = 0;
  logic [CNT_W-1:0] mdl_cnt = '0;
  int               checks = 0;
  int               errors = 0;

  logic_result_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_sel     (in_sel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_sel    (out_sel),
    .out_zero   (out_zero),
    .out_neg    (out_neg),
    .out_parity (out_parity),
    .level      (level),
    .done_cnt   (done_cnt)
  );

  always #5 clk = ~clk;

  // Reference occupancy model and expected-entry queue.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_level <= 0;
      mdl_cnt   <= '0;
      exp_q.delete();
    end else begin
      if (out_ready && mdl_level != 0) begin
        $display("pop  result=%08h sel=%0d flags=%03b", exp_q[0].r, exp_q[0].s, exp_q[0].f);
        void'(exp_q.pop_front());
        mdl_cnt <= mdl_cnt + 1'b1;
      end
      if (in_valid && mdl_level < DEPTH)
        exp_q.push_back('{r: in_result, s: in_sel, f: exp_flags});
      mdl_level <= mdl_level + ((in_valid && mdl_level < DEPTH) ? 1 : 0)
                             - ((out_ready && mdl_level != 0) ? 1 : 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: after each falling clock edge and right after reset assertion
  // (no clock edge needed), compare all outputs with the model.
  initial begin
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      chk("in_ready", 32'(in_ready), 32'(mdl_level < DEPTH));
      chk("out_valid", 32'(out_valid), 32'(mdl_level != 0));
      chk("level", 32'(level), 32'(mdl_level));
      chk("done_cnt", 32'(done_cnt), 32'(mdl_cnt));
      if (mdl_level != 0 && exp_q.size() != 0) begin
        chk("out_result", out_result, exp_q[0].r);
        chk("out_sel", 32'(out_sel), 32'(exp_q[0].s));
        chk("out_flags", 32'({out_zero, out_neg, out_parity}), 32'(exp_q[0].f));
      end else begin
        chk("empty_result", out_result, 32'h0);
        chk("empty_sel_flags", 32'({out_sel, out_zero, out_neg, out_parity}), 32'h0);
      end
    end
  end

  // One stimulus cycle: drive just after a rising edge, hold until the next.
  task automatic drive(input logic v, input logic r, input logic [31:0] d,
                       input logic [2:0] s, input logic [2:0] f);
    in_valid  = v;
    out_ready = r;
    in_result = d;
    in_sel    = s;
    exp_flags = f;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] ref_flags(input logic [31:0] d);
    logic p;
    p = 1'b0;
    for (int b = 0; b < 32; b++) p = p ^ d[b];
    return {(d == 32'h0), d[31], p};
  endfunction

  initial begin
    // Reset held across a few edges, released away from the clock edge.
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single push, head visible next cycle, then pop.
    drive(1'b1, 1'b0, 32'hFFFF0000, 3'd1, 3'b010);
    drive(1'b0, 1'b0, 32'h0, 3'd0, 3'b000);
    drive(1'b0, 1'b1, 32'h0, 3'd0, 3'b000);

    // Fill to full; third valid must be refused.
    drive(1'b1, 1'b0, 32'h00000000, 3'd2, 3'b100);
    drive(1'b1, 1'b0, 32'h00000001, 3'd3, 3'b001);
    drive(1'b1, 1'b0, 32'hDEADBEEF, 3'd4, 3'b010);
    drive(1'b1, 1'b1, 32'hDEADBEEF, 3'd4, 3'b010);
    drive(1'b0, 1'b1, 32'h0, 3'd0, 3'b000);
    drive(1'b0, 1'b1, 32'h0, 3'd0, 3'b000);

    // Simultaneous push and pop at level 1.
    drive(1'b1, 1'b0, 32'hA5A5A5A5, 3'd5, 3'b010);
    drive(1'b1, 1'b1, 32'h80000001, 3'd6, 3'b010);
    drive(1'b0, 1'b0, 32'h0, 3'd0, 3'b000);
    drive(1'b0, 1'b1, 32'h0, 3'd0, 3'b000);

    // Streaming push/pop: pointers wrap and done_cnt wraps (2-bit).
    drive(1'b1, 1'b1, 32'h00000003, 3'd7, 3'b000);
    drive(1'b1, 1'b1, 32'h7FFFFFFF, 3'd0, 3'b001);
    drive(1'b1, 1'b1, 32'h80000000, 3'd1, 3'b011);
    drive(1'b1, 1'b1, 32'h12345678, 3'd2, 3'b001);
    drive(1'b1, 1'b1, 32'h0000FFFF, 3'd3, 3'b000);
    drive(1'b0, 1'b1, 32'h0, 3'd0, 3'b000);
    drive(1'b0, 1'b0, 32'h0, 3'd0, 3'b000);

    // Fill to level 2, then assert reset between clock edges.
    drive(1'b1, 1'b0, 32'h0F0F0F0F, 3'd4, 3'b000);
    drive(1'b1, 1'b0, 32'hF0000000, 3'd5, 3'b010);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Push on the first edge after reset release.
    drive(1'b1, 1'b0, 32'h00000080, 3'd6, 3'b001);
    drive(1'b0, 1'b1, 32'h0, 3'd0, 3'b000);

    // Random traffic against the reference flags.
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] d;
      d = {$urandom_range(0, 65535), $urandom_range(0, 65535)};
      if ($urandom_range(0, 7) == 0) d = 32'h0;
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), d,
            3'($urandom_range(0, 7)), ref_flags(d));
    end

    // Drain.
    repeat (4) drive(1'b0, 1'b1, 32'h0, 3'd0, 3'b000);
    @(negedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
